// File: rtl/vc_transaction_layer.sv
// Main FIFO feeding NUM_VC virtual-channel FIFOs, drained through one registered output
// port under strict-priority or round-robin arbitration, plus the link-state controller.
module vc_transaction_layer #(
  parameter int DATA_WIDTH = 6,
  parameter int DEPTH      = 4,
  parameter int NUM_VC     = 2,
  localparam int VCW = $clog2(NUM_VC),
  localparam int CW  = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic                  wr_enable,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [CW-1:0]         umbral_main,
  input  logic [CW-1:0]         umbral_vc,
  input  logic                  arb_mode,
  input  logic                  out_pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  out_valid,
  output logic                  almost_full_main,
  output logic [NUM_VC-1:0]     vc_empty,
  output logic [2:0]            state_out,
  output logic                  error_out,
  output logic                  active_out,
  output logic                  idle_out
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_INIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_ACTIVE = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0] main_mem [DEPTH];
  logic [AW-1:0]         main_rd, main_wr;
  logic [CW-1:0]         main_cnt;
  logic [DATA_WIDTH-1:0] vc_mem [NUM_VC][DEPTH];
  logic [AW-1:0]         vc_rd  [NUM_VC];
  logic [AW-1:0]         vc_wr  [NUM_VC];
  logic [CW-1:0]         vc_cnt [NUM_VC];
  logic [CW-1:0]         umb_main_q, umb_vc_q;
  logic                  mode_q;
  logic [VCW-1:0]        last_grant;

  // Thresholds of 0 or beyond the FIFO depth mean "full depth".
  function automatic logic [CW-1:0] eff_thr(input logic [CW-1:0] v);
    return (v == '0 || v > FULL) ? FULL : v;
  endfunction

  logic                  open, flow, main_full, push, xfer, any_ne, load, drop_valid, err_ev, busy;
  logic [DATA_WIDTH-1:0] head;
  logic [VCW-1:0]        head_vc, rr_base, grant;
  logic [NUM_VC-1:0]     vc_push, vc_pop;

  always_comb begin
    // NOTE: every signal gets a default at the top so no path can infer a latch.
    grant      = '0;
    any_ne     = 1'b0;
    vc_push    = '0;
    vc_pop     = '0;
    vc_empty   = '0;
    open       = (state_q == S_IDLE) || (state_q == S_ACTIVE);
    flow       = open || (state_q == S_ERROR);
    main_full  = (main_cnt == FULL);
    push       = open && wr_enable && !main_full;
    head       = main_mem[main_rd];
    head_vc    = head[DATA_WIDTH-1 -: VCW];
    xfer       = flow && (main_cnt != '0) && (vc_cnt[head_vc] < eff_thr(umb_vc_q));
    // Strict priority scans from VC0; round-robin scans from the VC after the last grant.
    rr_base    = mode_q ? last_grant + VCW'(1) : '0;
    for (int i = 0; i < NUM_VC; i++) begin
      if (!any_ne && vc_cnt[rr_base + VCW'(i)] != '0) begin
        any_ne = 1'b1;
        grant  = rr_base + VCW'(i);
      end
    end
    load       = flow && (!out_valid || out_pop) && any_ne;
    drop_valid = flow && out_pop && !any_ne;
    err_ev     = open && ((wr_enable && main_full) || (out_pop && !out_valid));
    busy       = out_valid || (main_cnt != '0);
    for (int v = 0; v < NUM_VC; v++) begin
      vc_push[v]  = xfer && (head_vc == VCW'(v));
      vc_pop[v]   = load && (grant == VCW'(v));
      vc_empty[v] = (vc_cnt[v] == '0);
      busy        = busy || (vc_cnt[v] != '0);
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q == S_RESET || init) begin
      state_d = S_INIT;
    end else begin
      case (state_q)
        S_INIT:   state_d = S_IDLE;
        S_IDLE:   state_d = err_ev ? S_ERROR : (busy ? S_ACTIVE : S_IDLE);
        S_ACTIVE: state_d = err_ev ? S_ERROR : (busy ? S_ACTIVE : S_IDLE);
        default:  state_d = state_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_RESET;
      main_rd    <= '0;
      main_wr    <= '0;
      main_cnt   <= '0;
      data_out   <= '0;
      out_valid  <= 1'b0;
      umb_main_q <= '0;
      umb_vc_q   <= '0;
      mode_q     <= 1'b0;
      last_grant <= VCW'(NUM_VC - 1);
      for (int v = 0; v < NUM_VC; v++) begin
        vc_rd[v]  <= '0;
        vc_wr[v]  <= '0;
        vc_cnt[v] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (state_q == S_INIT) begin
        main_rd    <= '0;
        main_wr    <= '0;
        main_cnt   <= '0;
        data_out   <= '0;
        out_valid  <= 1'b0;
        umb_main_q <= umbral_main;
        umb_vc_q   <= umbral_vc;
        mode_q     <= arb_mode;
        for (int v = 0; v < NUM_VC; v++) begin
          vc_rd[v]  <= '0;
          vc_wr[v]  <= '0;
          vc_cnt[v] <= '0;
        end
      end else begin
        if (push) main_wr <= main_wr + AW'(1);
        if (xfer) main_rd <= main_rd + AW'(1);
        main_cnt <= main_cnt + CW'(push) - CW'(xfer);
        for (int v = 0; v < NUM_VC; v++) begin
          if (vc_push[v]) vc_wr[v] <= vc_wr[v] + AW'(1);
          if (vc_pop[v])  vc_rd[v] <= vc_rd[v] + AW'(1);
          vc_cnt[v] <= vc_cnt[v] + CW'(vc_push[v]) - CW'(vc_pop[v]);
        end
        if (load) begin
          data_out   <= vc_mem[grant][vc_rd[grant]];
          out_valid  <= 1'b1;
          last_grant <= grant;
        end else if (drop_valid) begin
          out_valid  <= 1'b0;
        end
      end
    end
  end

  // NOTE: storage arrays carry no reset; counters and pointers decide which entries are live.
  always_ff @(posedge clk) begin
    if (push) main_mem[main_wr] <= data_in;
    for (int v = 0; v < NUM_VC; v++) begin
      if (vc_push[v]) vc_mem[v][vc_wr[v]] <= head;
    end
  end

  assign almost_full_main = (main_cnt >= eff_thr(umb_main_q));
  assign state_out        = state_q;
  assign error_out        = (state_q == S_ERROR);
  assign active_out       = (state_q == S_ACTIVE);
  assign idle_out         = (state_q == S_IDLE);

endmodule

// File: tb/tb_vc_transaction_layer.sv
// Bench for vc_transaction_layer: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_vc_transaction_layer;
  localparam int DW     = 6;
  localparam int DEPTH  = 4;
  localparam int NUM_VC = 2;
  localparam int VCW    = 1;
  localparam int CW     = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          init = 1'b0;
  logic          wr_enable = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [CW-1:0] umbral_main = '0;
  logic [CW-1:0] umbral_vc = '0;
  logic          arb_mode = 1'b0;
  logic          out_pop = 1'b0;
  logic [DW-1:0] data_out;
  logic          out_valid;
  logic          almost_full_main;
  logic [NUM_VC-1:0] vc_empty;
  logic [2:0]    state_out;
  logic          error_out, active_out, idle_out;

  int checks = 0;
  int errors = 0;

  vc_transaction_layer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .NUM_VC(NUM_VC)) dut (
    .clk(clk), .reset(reset), .init(init), .wr_enable(wr_enable), .data_in(data_in),
    .umbral_main(umbral_main), .umbral_vc(umbral_vc), .arb_mode(arb_mode), .out_pop(out_pop),
    .data_out(data_out), .out_valid(out_valid), .almost_full_main(almost_full_main),
    .vc_empty(vc_empty), .state_out(state_out), .error_out(error_out),
    .active_out(active_out), .idle_out(idle_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: link state as 0..4, FIFOs as queues.
  int            m_st;
  logic [DW-1:0] m_main [$];
  logic [DW-1:0] m_vc [NUM_VC][$];
  logic          m_ov;
  logic [DW-1:0] m_dout;
  int            m_um, m_uv, m_lg;
  logic          m_mode;

  function automatic int eff(input int v);
    return (v == 0 || v > DEPTH) ? DEPTH : v;
  endfunction

  task automatic model_reset();
    m_st = 0;
    m_main.delete();
    for (int k = 0; k < NUM_VC; k++) m_vc[k].delete();
    m_ov = 1'b0; m_dout = '0; m_um = 0; m_uv = 0; m_mode = 1'b0; m_lg = NUM_VC - 1;
  endtask

  task automatic model_step();
    bit open, flow, busy, err, do_push;
    int nxt, g, xv;
    open = (m_st == 2 || m_st == 3);
    flow = open || m_st == 4;
    busy = m_ov || m_main.size() > 0;
    for (int k = 0; k < NUM_VC; k++) if (m_vc[k].size() > 0) busy = 1;
    err = open && ((wr_enable && m_main.size() == DEPTH) || (out_pop && !m_ov));
    if (m_st == 0 || init)      nxt = 1;
    else if (m_st == 1)         nxt = 2;
    else if (m_st == 4)         nxt = 4;
    else if (err)               nxt = 4;
    else                        nxt = busy ? 3 : 2;
    if (m_st == 1) begin
      m_main.delete();
      for (int k = 0; k < NUM_VC; k++) m_vc[k].delete();
      m_ov = 1'b0; m_dout = '0;
      m_um = int'(umbral_main); m_uv = int'(umbral_vc); m_mode = arb_mode;
    end else if (flow) begin
      g = -1;
      for (int k = 1; k <= NUM_VC; k++) begin
        int c;
        c = m_mode ? (m_lg + k) % NUM_VC : k - 1;
        if (g < 0 && m_vc[c].size() > 0) g = c;
      end
      xv = -1;
      if (m_main.size() > 0) begin
        xv = int'(m_main[0] >> (DW - VCW));
        if (m_vc[xv].size() >= eff(m_uv)) xv = -1;
      end
      do_push = open && wr_enable && m_main.size() < DEPTH;
      if ((!m_ov || out_pop) && g >= 0) begin
        m_dout = m_vc[g].pop_front(); m_ov = 1'b1; m_lg = g;
      end else if (out_pop) begin
        m_ov = 1'b0;
      end
      if (xv >= 0) m_vc[xv].push_back(m_main.pop_front());
      if (do_push) m_main.push_back(data_in);
    end
    m_st = nxt;
  endtask

  always @(posedge clk or negedge reset) begin
    logic [NUM_VC-1:0] e;
    if (!reset) model_reset();
    else        model_step();
    #1;
    for (int k = 0; k < NUM_VC; k++) e[k] = (m_vc[k].size() == 0);
    check("state_out", state_out, m_st);
    check("out_valid", out_valid, m_ov);
    check("data_out", data_out, m_dout);
    check("vc_empty", vc_empty, e);
    check("almost_full_main", almost_full_main, m_main.size() >= eff(m_um));
    check("error_out", error_out, m_st == 4);
    check("active_out", active_out, m_st == 3);
    check("idle_out", idle_out, m_st == 2);
  end

  logic [DW-1:0] got_q [$];

  task automatic wr(input logic [DW-1:0] d);
    wr_enable = 1'b1; data_in = d;
    @(negedge clk);
    wr_enable = 1'b0;
  endtask

  task automatic drain(input int n);
    got_q.delete();
    for (int c = 0; c < 4 * n + 8 && got_q.size() < n; c++) begin
      if (out_valid) begin got_q.push_back(data_out); out_pop = 1'b1; end
      else out_pop = 1'b0;
      @(negedge clk);
    end
    out_pop = 1'b0;
    check("drain_count", got_q.size(), n);
  endtask

  task automatic do_init(input logic mode, input logic [CW-1:0] um, input logic [CW-1:0] uv);
    init = 1'b1; arb_mode = mode; umbral_main = um; umbral_vc = uv;
    repeat (2) @(negedge clk);
    init = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    umbral_main = 3'd3; umbral_vc = 3'd2;
    repeat (2) @(negedge clk);
    check("rst_state", state_out, 0);
    check("rst_valid", out_valid, 0);
    check("rst_vc_empty", vc_empty, 2'b11);
    init = 1'b1; reset = 1'b1;
    @(negedge clk);
    check("init_state", state_out, 1);
    @(negedge clk);
    init = 1'b0;
    @(negedge clk);
    check("idle_state", state_out, 2);
    check("idle_flag", idle_out, 1);

    // Single word to VC1, two-cycle latency.
    wr(6'b100101);
    repeat (2) @(negedge clk);
    check("single_data", data_out, 6'h25);
    check("single_valid", out_valid, 1);
    check("single_active", active_out, 1);
    out_pop = 1'b1;
    @(negedge clk);
    out_pop = 1'b0;
    @(negedge clk);
    check("single_back_idle", idle_out, 1);

    // Strict priority: VC0 A,B then VC1 C.
    wr(6'h05); wr(6'h0A); wr(6'h23);
    repeat (3) @(negedge clk);
    drain(3);
    check("sp_0", got_q[0], 6'h05);
    check("sp_1", got_q[1], 6'h0A);
    check("sp_2", got_q[2], 6'h23);
    repeat (2) @(negedge clk);

    // Round-robin: VC0 A,B and VC1 C,D interleave.
    do_init(1'b1, 3'd3, 3'd2);
    wr(6'h05); wr(6'h0A); wr(6'h23); wr(6'h31);
    repeat (3) @(negedge clk);
    drain(4);
    check("rr_0", got_q[0], 6'h05);
    check("rr_1", got_q[1], 6'h23);
    check("rr_2", got_q[2], 6'h0A);
    check("rr_3", got_q[3], 6'h31);
    repeat (2) @(negedge clk);

    // Overflow: eight VC0 writes with no draining.
    do_init(1'b0, 3'd3, 3'd2);
    for (int i = 1; i <= 8; i++) wr(DW'(i));
    check("ovf_state", state_out, 4);
    check("ovf_error", error_out, 1);
    check("ovf_out", data_out, 6'h01);
    check("ovf_almost_full", almost_full_main, 1);
    check("ovf_vc_empty", vc_empty, 2'b10);

    // Recovery from ERROR through INIT.
    init = 1'b1;
    @(negedge clk);
    check("rec_state", state_out, 1);
    check("rec_error", error_out, 0);
    @(negedge clk);
    check("rec_vc_empty", vc_empty, 2'b11);
    check("rec_valid", out_valid, 0);
    check("rec_almost_full", almost_full_main, 0);
    init = 1'b0;
    @(negedge clk);
    check("rec_idle", state_out, 2);

    // Asynchronous reset with words in flight.
    wr(6'h11); wr(6'h2C); wr(6'h07);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_state", state_out, 0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_vc_empty", vc_empty, 2'b11);
    @(negedge clk);
    reset = 1'b1;
    do_init(1'b0, 3'd0, 3'd0);

    // Randomized traffic; the model checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      wr_enable = ($urandom_range(0, 2) != 0);
      data_in   = DW'($urandom);
      out_pop   = out_valid ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 19) == 0);
      init      = ($urandom_range(0, 29) == 0);
      if (init) begin
        umbral_main = CW'($urandom);
        umbral_vc   = CW'($urandom);
        arb_mode    = ($urandom_range(0, 1) == 1);
      end
      if ($urandom_range(0, 399) == 0) begin
        #2 reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
      end
      @(negedge clk);
    end
    wr_enable = 1'b0; out_pop = 1'b0; init = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vc_transaction_layer.md
# vc_transaction_layer

Parametrised successor to the fixed two-VC transaction datapath. It buffers incoming words in a main FIFO and routes each word by header bits into one of NUM_VC virtual-channel FIFOs. A single registered output port drains the VC FIFOs under strict-priority or round-robin arbitration. An integrated RESET/INIT/IDLE/ACTIVE/ERROR controller latches the almost-full thresholds and reports link status.

## Interface
- DATA_WIDTH, 6: word width; must be ≥ VCW+1.
- DEPTH, 4: entries per FIFO (main and each VC); power of 2, ≥ 2.
- NUM_VC, 2: number of virtual channels; power of 2, ≥ 2.
- Derived VCW = $clog2(NUM_VC), CW = $clog2(DEPTH)+1.

- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- init  in  1  enter/hold INIT; latch thresholds and mode.
- wr_enable  in  1  push data_in into main FIFO.
- data_in  in  DATA_WIDTH  word; VC index = data_in[DATA_WIDTH-1 -: VCW].
- umbral_main  in  CW  main FIFO almost-full threshold.
- umbral_vc  in  CW  per-VC almost-full threshold (shared).
- arb_mode  in  1  0 = strict priority, 1 = round-robin.
- out_pop  in  1  downstream consumes data_out this cycle.
- data_out  out  DATA_WIDTH  registered output word.
- out_valid  out  1  data_out holds an unconsumed word.
- almost_full_main  out  1  main count ≥ latched umbral_main.
- vc_empty  out  NUM_VC  per-VC empty flags.
- state_out  out  3  RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.
- error_out, active_out, idle_out  out  1 each  registered state decodes.

## Operation
- Reset (reset=0): all FIFOs flushed, counters/pointers 0, data_out=0, out_valid=0, thresholds=0, mode=0, last_grant=NUM_VC-1, state RESET, all status outputs 0 except vc_empty = all ones.
- State machine (registered; next state computed from current values):
  - RESET → INIT unconditionally on first edge after release.
  - INIT: flush all FIFOs and the output register; latch umbral_main, umbral_vc, arb_mode each cycle. Exit to IDLE when init=0.
  - IDLE → ACTIVE when any FIFO non-empty or out_valid=1; ACTIVE → IDLE when all empty and out_valid=0.
  - Any of IDLE/ACTIVE → ERROR on error event.
  - ERROR is sticky; exits only via reset or init=1.
  - init=1 in any non-RESET state → INIT (highest priority after reset).
- Threshold rule: a latched value of 0 or > DEPTH is treated as DEPTH.
- Push: accepted only in IDLE/ACTIVE. It is rejected when main count == DEPTH, regardless of a same-cycle transfer out. wr_enable is ignored in RESET/INIT/ERROR.
- Transfer main→VC: at most one word per cycle. It moves the main head to VC[index] when that VC's count < latched umbral_vc. Otherwise it stalls (head-of-line blocking, no reordering).
- Output load: when out_valid=0 or out_pop=1, and some VC is non-empty, pop the granted VC into data_out and set out_valid=1. If no VC is non-empty, out_pop=1 clears out_valid.
- Arbitration: mode 0 grants the lowest-index non-empty VC. Mode 1 grants the first non-empty VC after last_grant (modulo NUM_VC); last_grant updates on each grant.
- Error events: push while main is full; out_pop while out_valid=0. Both move the state to ERROR. Data flow (transfer/drain) continues in ERROR.

## Timing
- A word sampled at edge E0 enters main at E0, moves to its VC at E1, and appears on data_out with out_valid=1 after E2, if unobstructed. Latency is 2 cycles.
- A VC pop and a push into the same VC in one cycle are both performed; the count is unchanged.
- Status outputs are registered from state and follow the state change by 0 cycles (Moore decode of the state register).
- almost_full_main and vc_empty are combinational from the counters.
- Reset asserted mid-transfer clears everything immediately (asynchronous). In-flight words are lost.

## Test plan
- Reset/init: reset=0 → state_out=0, out_valid=0. Release, then init=1 with umbral_main=3, umbral_vc=2 → state_out=1. Then init=0 → state_out=2, idle_out=1.
- Single word (NUM_VC=2): write 6'b100101 at E0 → data_out=6'h25, out_valid=1 after E2, active_out=1. Pop → IDLE one edge later.
- Strict priority: with out_pop=0, load VC0 with A,B and VC1 with C. Then hold out_pop=1 → order A,B,C on data_out.
- Round-robin (arb_mode=1 latched in INIT): load VC0 A,B and VC1 C,D → order A,C,B,D.
- Overflow (DEPTH=4, umbral_vc=2, out_pop=0): 8 consecutive VC0 writes. Words 1–7 are held (1 in output, 2 in VC0, 4 in main). The 8th is dropped, and error_out=1 with state_out=4 after that edge.
- Mid-operation reset and error recovery: reset=0 while words are in flight → immediate flush, state_out=0. Separately, from ERROR, init=1 → INIT with all FIFOs empty, error_out=0.
